// File: rtl/simon_pkg.sv
// Shared constants, FSM state type and word-level helpers for the Simon32/64
// decryption core.
package simon_pkg;

    localparam int WORD_W        = 16;
    localparam int KEY_WORDS     = 4;
    localparam int KEY_W         = WORD_W * KEY_WORDS;
    localparam int ROUNDS        = 32;
    localparam int KEY_FWD_STEPS = 28;

    // z0 constant sequence, written in reading order: element 0 sits in bit 61.
    localparam logic [61:0] Z0 =
        62'b11111010001001010110000111001101111101000100101011000011100110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEY  = 2'd1,
        DEC  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        SCHED_FWD = 1'b0,
        SCHED_INV = 1'b1
    } sched_dir_t;

    // Rotate a word left by n bits (0 < n < WORD_W).
    function automatic logic [WORD_W-1:0] rol_w(input logic [WORD_W-1:0] v,
                                                input int unsigned     n);
        return (v << n) | (v >> (WORD_W - n));
    endfunction

    // Rotate a word right by n bits (0 < n < WORD_W).
    function automatic logic [WORD_W-1:0] ror_w(input logic [WORD_W-1:0] v,
                                                input int unsigned     n);
        return (v >> n) | (v << (WORD_W - n));
    endfunction

    // Element idx of the z0 sequence; indices past the sequence read as zero.
    function automatic logic z0_bit(input logic [5:0] idx);
        logic [5:0] pos;
        if (idx > 6'd61) begin
            return 1'b0;
        end else begin
            pos = 6'd61 - idx;
            return Z0[pos];
        end
    endfunction

    // Simon round function f(v) = (v rol 1 & v rol 8) ^ (v rol 2).
    function automatic logic [WORD_W-1:0] simon_f(input logic [WORD_W-1:0] v);
        return (rol_w(v, 1) & rol_w(v, 8)) ^ rol_w(v, 2);
    endfunction

endpackage

// File: rtl/simon_key_step.sv
// One step of the Simon32/64 key schedule over a four-word sliding window.
// Forward: {k[i+3..i]} -> {k[i+4..i+1]}.  Inverse: {k[i+4..i+1]} -> {k[i+3..i]}.
module simon_key_step
    import simon_pkg::*;
(
    input  sched_dir_t         dir,
    input  logic               z_bit,
    input  logic [KEY_W-1:0]   win,
    output logic [KEY_W-1:0]   win_next
);

    logic [WORD_W-1:0] w0_s;
    logic [WORD_W-1:0] w1_s;
    logic [WORD_W-1:0] w2_s;
    logic [WORD_W-1:0] w3_s;
    logic [WORD_W-1:0] t_s;
    logic [WORD_W-1:0] zc_s;
    logic [WORD_W-1:0] word_s;

    assign w0_s = win[WORD_W-1:0];
    assign w1_s = win[2*WORD_W-1:WORD_W];
    assign w2_s = win[3*WORD_W-1:2*WORD_W];
    assign w3_s = win[4*WORD_W-1:3*WORD_W];

    // Constant term z0[i] ^ 3 as a full word.
    assign zc_s = 16'h0003 ^ {15'h0000, z_bit};

    // Compute the new window word and slide the window in the chosen direction.
    always_comb begin
        t_s      = 16'h0000;
        word_s   = 16'h0000;
        win_next = {KEY_W{1'b0}};
        if (dir == SCHED_INV) begin
            // Window holds k[i+4..i+1]; recover k[i] and shift it in at the bottom.
            t_s      = ror_w(w2_s, 3) ^ w0_s;
            word_s   = ~(w3_s ^ t_s ^ ror_w(t_s, 1) ^ zc_s);
            win_next = {w2_s, w1_s, w0_s, word_s};
        end else begin
            // Window holds k[i+3..i]; produce k[i+4] and shift it in at the top.
            t_s      = ror_w(w3_s, 3) ^ w1_s;
            word_s   = ~w0_s ^ t_s ^ ror_w(t_s, 1) ^ zc_s;
            win_next = {word_s, w3_s, w2_s, w1_s};
        end
    end

endmodule

// File: rtl/simon_decrypt.sv
// Iterative Simon32/64 decryption core.  An accepted block first runs the key
// schedule forward to the last round key, then peels rounds off from 31 down to
// 0 while walking the schedule backwards, so only a four-word key window is kept.
module simon_decrypt
    import simon_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         ciphertext,
    input  logic [KEY_W-1:0]    key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         plaintext,
    output logic                busy
);

    localparam logic [5:0] KEY_LAST = 6'(KEY_FWD_STEPS - 1);
    localparam logic [5:0] DEC_LAST = 6'(ROUNDS - 1);

    state_t             state_r;
    state_t             state_s;
    logic [5:0]         step_r;
    logic [5:0]         zi_r;
    logic [WORD_W-1:0]  x_r;
    logic [WORD_W-1:0]  y_r;
    logic [KEY_W-1:0]   key_win_r;
    logic [31:0]        plaintext_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               busy_r;

    sched_dir_t         dir_s;
    logic               z_bit_s;
    logic [KEY_W-1:0]   key_win_nxt_s;
    logic [WORD_W-1:0]  round_x_s;
    logic [WORD_W-1:0]  round_y_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign plaintext = plaintext_r;

    simon_key_step u_key_step (
        .dir      (dir_s),
        .z_bit    (z_bit_s),
        .win      (key_win_r),
        .win_next (key_win_nxt_s)
    );

    // Schedule direction and z0 element for the current step.  In DEC the
    // counter sits one above the index being undone; once it reaches zero the
    // remaining inverse steps only need to shift the window.
    always_comb begin
        dir_s   = SCHED_FWD;
        z_bit_s = 1'b0;
        if (state_r == DEC) begin
            dir_s = SCHED_INV;
            if (zi_r != 6'd0) begin
                z_bit_s = z0_bit(zi_r - 6'd1);
            end else begin
                z_bit_s = 1'b0;
            end
        end else begin
            dir_s   = SCHED_FWD;
            z_bit_s = z0_bit(zi_r);
        end
    end

    // One inverse Feistel round with the top window word as round key.
    always_comb begin
        round_x_s = y_r;
        round_y_s = x_r ^ simon_f(y_r) ^ key_win_r[KEY_W-1:KEY_W-WORD_W];
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = KEY;
                end else begin
                    state_s = IDLE;
                end
            end
            KEY: begin
                if (step_r == KEY_LAST) begin
                    state_s = DEC;
                end else begin
                    state_s = KEY;
                end
            end
            DEC: begin
                if (step_r == DEC_LAST) begin
                    state_s = DONE;
                end else begin
                    state_s = DEC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register and status flags, all derived from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
            busy_r      <= (state_s == KEY) || (state_s == DEC);
        end
    end

    // Datapath: capture on accept, walk the schedule, run the rounds.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_r      <= 6'd0;
            zi_r        <= 6'd0;
            x_r         <= 16'h0000;
            y_r         <= 16'h0000;
            key_win_r   <= {KEY_W{1'b0}};
            plaintext_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        x_r       <= ciphertext[31:16];
                        y_r       <= ciphertext[15:0];
                        key_win_r <= key;
                        step_r    <= 6'd0;
                        zi_r      <= 6'd0;
                    end else begin
                        step_r    <= step_r;
                    end
                end
                KEY: begin
                    key_win_r <= key_win_nxt_s;
                    zi_r      <= zi_r + 6'd1;
                    if (step_r == KEY_LAST) begin
                        step_r <= 6'd0;
                    end else begin
                        step_r <= step_r + 6'd1;
                    end
                end
                DEC: begin
                    x_r       <= round_x_s;
                    y_r       <= round_y_s;
                    key_win_r <= key_win_nxt_s;
                    step_r    <= step_r + 6'd1;
                    if (zi_r != 6'd0) begin
                        zi_r <= zi_r - 6'd1;
                    end else begin
                        zi_r <= 6'd0;
                    end
                    if (step_r == DEC_LAST) begin
                        plaintext_r <= {round_x_s, round_y_s};
                    end else begin
                        plaintext_r <= plaintext_r;
                    end
                end
                DONE: begin
                    plaintext_r <= plaintext_r;
                end
                default: begin
                    step_r <= 6'd0;
                    zi_r   <= 6'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_decrypt.sv
// Directed and round-trip bench for simon_decrypt.
module tb_simon_decrypt;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ciphertext;
    logic [63:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] plaintext;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    localparam logic [63:0] KAT_KEY = 64'h1918_1110_0908_0100;
    localparam logic [31:0] KAT_CT  = 32'hc69b_e9bb;
    localparam logic [31:0] KAT_PT  = 32'h6565_6877;
    localparam logic [61:0] ZSEQ    =
        62'b11111010001001010110000111001101111101000100101011000011100110;

    simon_decrypt dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a block and return once the accept edge has passed.
    task automatic offer_accept(input logic [31:0] ct, input logic [63:0] k, output int acc_cyc);
        int guard;
        ciphertext = ct;
        key        = k;
        in_valid   = 1'b1;
        guard      = 0;
        while (!in_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        acc_cyc = cyc;
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        if (lat >= 200) check("out_valid_timeout", 64'd0, 64'd1);
    endtask

    function automatic logic [15:0] m_f(input logic [15:0] v);
        logic [15:0] r1, r2, r8;
        r1 = {v[14:0], v[15]};
        r2 = {v[13:0], v[15:14]};
        r8 = {v[7:0], v[15:8]};
        return (r1 & r8) ^ r2;
    endfunction

    // Reference Simon32/64 encryption: full round-key table, then 32 rounds.
    function automatic logic [31:0] ref_encrypt(input logic [63:0] k, input logic [31:0] p);
        logic [15:0] rk [32];
        logic [15:0] x, y, t, tmp;
        logic        zb;
        for (int i = 0; i < 4; i++) rk[i] = k[16*i +: 16];
        for (int i = 0; i < 28; i++) begin
            t  = {rk[i+3][2:0], rk[i+3][15:3]} ^ rk[i+1];
            t  = t ^ {t[0], t[15:1]};
            zb = ZSEQ[61-i];
            rk[i+4] = 16'hfffc ^ {15'd0, zb} ^ rk[i] ^ t;
        end
        x = p[31:16];
        y = p[15:0];
        for (int i = 0; i < 32; i++) begin
            tmp = x;
            x   = y ^ m_f(x) ^ rk[i];
            y   = tmp;
        end
        return {x, y};
    endfunction

    initial begin
        int          lat, acc, prev_acc;
        logic [31:0] pt, ct;
        logic [63:0] k;

        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        ciphertext = 32'd0;
        key        = 64'd0;
        tick();
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_plaintext", 64'(plaintext), 64'd0);
        rst = 1'b0;
        tick();

        // Known answer with latency and busy/ready during compute.
        offer_accept(KAT_CT, KAT_KEY, acc);
        check("kat_busy",     64'(busy),     64'd1);
        check("kat_in_ready", 64'(in_ready), 64'd0);
        wait_out(lat);
        check("kat_latency",   64'(lat),       64'd60);
        check("kat_plaintext", 64'(plaintext), 64'(KAT_PT));
        check("kat_busy_done", 64'(busy),      64'd0);

        // Backpressure: hold result for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_plaintext", 64'(plaintext), 64'(KAT_PT));
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready",  64'(in_ready),  64'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hs_in_ready",  64'(in_ready),  64'd1);
        check("hs_out_valid", 64'(out_valid), 64'd0);

        // Inputs altered after the accept edge.
        offer_accept(KAT_CT, KAT_KEY, acc);
        tick();
        ciphertext = 32'd0;
        key        = 64'd0;
        wait_out(lat);
        check("chg_latency",   64'(lat + 1),   64'd60);
        check("chg_plaintext", 64'(plaintext), 64'(KAT_PT));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset at DEC round 10 (edge 50 after accept).
        offer_accept(KAT_CT, KAT_KEY, acc);
        repeat (49) @(posedge clk);
        #1;
        check("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_in_ready",  64'(in_ready),  64'd1);
        check("mrst_out_valid", 64'(out_valid), 64'd0);
        check("mrst_plaintext", 64'(plaintext), 64'd0);
        check("mrst_busy",      64'(busy),      64'd0);
        offer_accept(KAT_CT, KAT_KEY, acc);
        wait_out(lat);
        check("post_rst_latency",   64'(lat),       64'd60);
        check("post_rst_plaintext", 64'(plaintext), 64'(KAT_PT));

        // Round trip, back to back with the consumer always ready.
        out_ready = 1'b1;
        prev_acc  = 0;
        for (int n = 0; n < 1000; n++) begin
            k  = {$urandom(), $urandom()};
            pt = $urandom();
            ct = ref_encrypt(k, pt);
            offer_accept(ct, k, acc);
            if (n > 0) check("rt_spacing", 64'(acc - prev_acc), 64'd62);
            prev_acc = acc;
            wait_out(lat);
            check("rt_plaintext", 64'(plaintext), 64'(pt));
        end
        out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
